// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multi-cycle multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic [1:0] MULDIV_OP_MULT  = 2'd0;
  localparam logic [1:0] MULDIV_OP_MULTU = 2'd1;
  localparam logic [1:0] MULDIV_OP_DIV   = 2'd2;
  localparam logic [1:0] MULDIV_OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDivZero,
    StDone
  } muldiv_state_e;

  // Replicated across the quotient on divide-by-zero.
  localparam logic DIVZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/ex_muldiv_step.sv
// One iteration of the muldiv datapath: shift-add multiply or restoring-divide step.
module ex_muldiv_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_lo,
  input  logic [DATA_W-1:0] i_operand,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shifted;
  logic [DATA_W-1:0] w_diff;
  logic              w_ge;

  always_comb begin
    w_sum     = {1'b0, i_hi};
    w_shifted = {i_hi, i_lo[DATA_W-1]};
    w_ge      = (w_shifted >= {1'b0, i_operand});
    // Difference is below the divisor whenever it is kept, so the low bits suffice.
    w_diff    = w_shifted[DATA_W-1:0] - i_operand;
    o_hi      = i_hi;
    o_lo      = i_lo;
    if (!i_is_div) begin
      if (i_lo[0]) begin
        w_sum = {1'b0, i_hi} + {1'b0, i_operand};
      end
      {o_hi, o_lo} = {w_sum, i_lo[DATA_W-1:1]};
    end else if (w_ge) begin
      o_hi = w_diff;
      o_lo = {i_lo[DATA_W-2:0], 1'b1};
    end else begin
      o_hi = w_shifted[DATA_W-1:0];
      o_lo = {i_lo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi,lo}; one result bit per cycle.
// Optional multiply early termination: define EX_MULDIV_EARLY_TERM_EN.
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [1:0]          op_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o,
  output logic                stallreq_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  muldiv_state_e       r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic                r_is_div, w_is_div_d;
  logic                r_neg_q, w_neg_q_d;
  logic                r_neg_r, w_neg_r_d;
  logic [DATA_W-1:0]   r_hi, w_hi_d;
  logic [DATA_W-1:0]   r_lo, w_lo_d;
  logic [DATA_W-1:0]   r_operand, w_operand_d;
  logic [DATA_W-1:0]   r_op1_raw, w_op1_raw_d;
  logic [2*DATA_W-1:0] r_result, w_result_d;

  logic [DATA_W-1:0]   w_step_hi, w_step_lo;
  logic                w_in_signed, w_in_div, w_s1, w_s2, w_accept;
  logic [DATA_W-1:0]   w_mag1, w_mag2;
  logic                w_early;
  logic [2*DATA_W-1:0] w_prod_raw, w_prod_fix, w_fixed;
  logic [DATA_W-1:0]   w_quot, w_rem;

  ex_muldiv_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_operand(r_operand),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  assign w_in_signed = (op_i == MULDIV_OP_MULT) || (op_i == MULDIV_OP_DIV);
  assign w_in_div    = (op_i == MULDIV_OP_DIV) || (op_i == MULDIV_OP_DIVU);
  assign w_s1        = w_in_signed & opdata1_i[DATA_W-1];
  assign w_s2        = w_in_signed & opdata2_i[DATA_W-1];
  // Negation wraps, so the most negative value is its own magnitude.
  assign w_mag1      = w_s1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_mag2      = w_s2 ? (~opdata2_i + 1'b1) : opdata2_i;
  assign w_accept    = (r_state == StIdle) && start_i && !annul_i;

`ifdef EX_MULDIV_EARLY_TERM_EN
  logic [DATA_W-1:0] r_mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mplier <= '0;
    end else if (w_accept) begin
      r_mplier <= w_mag2;
    end else if (r_state == StCalc) begin
      r_mplier <= r_mplier >> 1;
    end
  end

  // Once no multiplier bits remain, realign the partial product by the skipped count.
  assign w_early    = !r_is_div && ((r_mplier >> 1) == '0);
  assign w_prod_raw = {w_step_hi, w_step_lo} >> (CNT_W'(DATA_W - 1) - r_cnt);
`else
  assign w_early    = 1'b0;
  assign w_prod_raw = {w_step_hi, w_step_lo};
`endif

  assign w_prod_fix = r_neg_q ? (~w_prod_raw + 1'b1) : w_prod_raw;
  assign w_quot     = r_neg_q ? (~w_step_lo + 1'b1) : w_step_lo;
  assign w_rem      = r_neg_r ? (~w_step_hi + 1'b1) : w_step_hi;
  assign w_fixed    = r_is_div ? {w_rem, w_quot} : w_prod_fix;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_is_div_d  = r_is_div;
    w_neg_q_d   = r_neg_q;
    w_neg_r_d   = r_neg_r;
    w_hi_d      = r_hi;
    w_lo_d      = r_lo;
    w_operand_d = r_operand;
    w_op1_raw_d = r_op1_raw;
    w_result_d  = r_result;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_is_div_d  = w_in_div;
          w_neg_q_d   = w_s1 ^ w_s2;
          w_neg_r_d   = w_s1;
          w_op1_raw_d = opdata1_i;
          w_hi_d      = '0;
          w_cnt_d     = '0;
          w_operand_d = w_in_div ? w_mag2 : w_mag1;
          w_lo_d      = w_in_div ? w_mag1 : w_mag2;
          w_state_d   = (w_in_div && (opdata2_i == '0)) ? StDivZero : StCalc;
        end
      end
      StCalc: begin
        if (annul_i || !start_i) begin
          w_state_d = StIdle;
        end else begin
          w_hi_d  = w_step_hi;
          w_lo_d  = w_step_lo;
          w_cnt_d = r_cnt + 1'b1;
          if ((r_cnt == CNT_W'(DATA_W - 1)) || w_early) begin
            w_state_d  = StDone;
            w_result_d = w_fixed;
          end
        end
      end
      StDivZero: begin
        if (annul_i || !start_i) begin
          w_state_d = StIdle;
        end else begin
          w_state_d  = StDone;
          w_result_d = {r_op1_raw, {DATA_W{DIVZERO_QUOT_BIT}}};
        end
      end
      StDone: begin
        if (annul_i || !start_i) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_operand <= '0;
      r_op1_raw <= '0;
      r_result  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_is_div  <= w_is_div_d;
      r_neg_q   <= w_neg_q_d;
      r_neg_r   <= w_neg_r_d;
      r_hi      <= w_hi_d;
      r_lo      <= w_lo_d;
      r_operand <= w_operand_d;
      r_op1_raw <= w_op1_raw_d;
      r_result  <= w_result_d;
    end
  end

  assign result_o   = r_result;
  assign ready_o    = (r_state == StDone);
  assign busy_o     = (r_state == StCalc);
  assign stallreq_o = start_i & ~ready_o & ~annul_i;

endmodule
